// File: rtl/matrix_loader_if.sv
// Byte-stream input and packed-matrix output handshakes between the loader and its neighbours.
// The slave modport is the loader's view; the master modport is the producer/consumer side.
interface matrix_loader_if #(
  parameter int DATA_W    = 8,
  parameter int MAX_ELEMS = 25
);
  logic [DATA_W-1:0]           in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [MAX_ELEMS*DATA_W-1:0] matrix_out;
  logic [DATA_W-1:0]           scalar_out;
  logic [1:0]                  size_out;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, matrix_out, scalar_out, size_out, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, matrix_out, scalar_out, size_out, out_valid
  );
endinterface

// File: rtl/matrix_loader.sv
// Collects N matrix bytes plus one scalar byte from a valid/ready stream and presents
// them, packed, to the scalar-multiply stage until the output handshake completes.
module matrix_loader #(
  parameter int DATA_W    = 8,
  parameter int MAX_ELEMS = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          matrix_size,
  matrix_loader_if.slave      bus,
  output logic                busy,
  output logic [4:0]          elem_count
);

  typedef enum logic [1:0] {IDLE, LOAD, SCALAR, HOLD} state_t;

  state_t                      state_q, state_d;
  logic [DATA_W-1:0]           scalar_q, scalar_d;
  logic [1:0]                  size_q, size_d;
  logic [4:0]                  count_q, count_d;
  logic                        out_valid_q, out_valid_d;
  logic [4:0]                  n_elems;
  logic                        xfer;
  logic                        clear_slots;
  logic                        write_elem;
  logic [MAX_ELEMS*DATA_W-1:0] matrix_w;

  always_comb begin
    case (size_q)
      2'b00:   n_elems = 5'd4;
      2'b01:   n_elems = 5'd9;
      2'b10:   n_elems = 5'd16;
      default: n_elems = 5'd25;
    endcase
  end

  assign xfer        = bus.in_valid && bus.in_ready;
  assign clear_slots = (state_q == IDLE) && start;
  assign write_elem  = (state_q == LOAD) && xfer;

  // State register and scalar/size/count/valid flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scalar_q    <= '0;
      size_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scalar_q    <= scalar_d;
      size_q      <= size_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    scalar_d = scalar_q;
    size_d   = size_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          size_d  = matrix_size;
          count_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          count_d = count_q + 5'd1;
          if (count_q == n_elems - 5'd1) state_d = SCALAR;
        end
      end
      SCALAR: begin
        if (xfer) begin
          scalar_d = bus.in_data;
          state_d  = HOLD;
        end
      end
      default: begin
        if (bus.out_ready) state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == HOLD);
  end

  // One register per matrix slot; only the slot addressed by the running count is written.
  for (genvar gi = 0; gi < MAX_ELEMS; gi++) begin : g_slot
    logic [DATA_W-1:0] slot_q, slot_d;

    always_comb begin
      slot_d = slot_q;
      if (clear_slots)
        slot_d = '0;
      else if (write_elem && (count_q == 5'(gi)))
        slot_d = bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) slot_q <= '0;
      else        slot_q <= slot_d;
    end

    assign matrix_w[gi*DATA_W +: DATA_W] = slot_q;
  end

  // Output decode
  always_comb begin
    bus.in_ready   = (state_q == LOAD) || (state_q == SCALAR);
    bus.out_valid  = out_valid_q;
    bus.matrix_out = matrix_w;
    bus.scalar_out = scalar_q;
    bus.size_out   = size_q;
    busy           = (state_q != IDLE);
    elem_count     = count_q;
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Randomised and directed bench for matrix_loader against a transaction-level model of a load.
module tb_matrix_loader;
  localparam int DW = 8;
  localparam int ME = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] matrix_size = 2'b00;
  logic       busy;
  logic [4:0] elem_count;

  matrix_loader_if #(.DATA_W(DW), .MAX_ELEMS(ME)) bus ();

  matrix_loader #(.DATA_W(DW), .MAX_ELEMS(ME)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix_size(matrix_size),
    .bus(bus), .busy(busy), .elem_count(elem_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: a load is "loading" until it has taken N elements and a scalar, then "holding"
  logic              m_loading, m_holding;
  int                m_n, m_cnt;
  logic [7:0]        m_mat [ME];
  logic [7:0]        m_scalar;
  logic [1:0]        m_size;
  logic [ME*DW-1:0]  exp_mat;

  function automatic int elems_for(input logic [1:0] sz);
    return (int'(sz) + 2) * (int'(sz) + 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading <= 1'b0;
      m_holding <= 1'b0;
      m_cnt     <= 0;
      m_n       <= 0;
      m_scalar  <= '0;
      m_size    <= '0;
      for (int i = 0; i < ME; i++) m_mat[i] <= '0;
    end else if (!m_loading && !m_holding) begin
      if (start) begin
        m_loading <= 1'b1;
        m_n       <= elems_for(matrix_size);
        m_cnt     <= 0;
        m_size    <= matrix_size;
        for (int i = 0; i < ME; i++) m_mat[i] <= '0;
      end
    end else if (m_loading) begin
      if (bus.in_valid) begin
        if (m_cnt < m_n) begin
          m_mat[m_cnt] <= bus.in_data;
          m_cnt        <= m_cnt + 1;
        end else begin
          m_scalar  <= bus.in_data;
          m_loading <= 1'b0;
          m_holding <= 1'b1;
        end
      end
    end else if (bus.out_ready) begin
      m_holding <= 1'b0;
    end
  end

  always_comb begin
    exp_mat = '0;
    for (int i = 0; i < ME; i++) exp_mat[i*DW +: DW] = m_mat[i];
  end

  always @(negedge clk) begin
    chk("in_ready",   200'(bus.in_ready),   200'(m_loading));
    chk("out_valid",  200'(bus.out_valid),  200'(m_holding));
    chk("busy",       200'(busy),           200'(m_loading || m_holding));
    chk("elem_count", 200'(elem_count),     200'(m_cnt));
    chk("matrix_out", 200'(bus.matrix_out), 200'(exp_mat));
    chk("scalar_out", 200'(bus.scalar_out), 200'(m_scalar));
    chk("size_out",   200'(bus.size_out),   200'(m_size));
  end

  logic [7:0] stim [26];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] sz);
    start       = 1'b1;
    matrix_size = sz;
    tick();
    start       = 1'b0;
    matrix_size = 2'($urandom);
  endtask

  // gap: 0 = continuous, >0 = in_valid low every gap-th cycle, <0 = random bubbles
  task automatic feed(input int first, input int count, input int gap);
    int sent = 0;
    int cyc  = 0;
    while (sent < count) begin
      cyc++;
      if ((gap > 0 && cyc % gap == 0) || (gap < 0 && $urandom_range(0, 3) == 0)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = stim[first + sent];
        sent++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic release_out(input int wait_cycles, input bit start_too, input logic [1:0] sz);
    for (int i = 0; i < wait_cycles; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'hAA;
      bus.out_ready = 1'b0;
      tick();
      chk("bp_in_ready", 200'(bus.in_ready), 200'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    start         = start_too;
    matrix_size   = sz;
    tick();
    bus.out_ready = 1'b0;
    start         = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_matrix", 200'(bus.matrix_out), 200'(0));
    chk("rst_busy",   200'(busy), 200'(0));
    rst_n = 1'b1;
    tick();

    // 2x2 continuous: out_valid exactly 6 cycles after start
    stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim[3] = 8'h04; stim[4] = 8'hFD;
    do_start(2'b00);
    feed(0, 4, 0);
    chk("t1_valid_early", 200'(bus.out_valid), 200'(0));
    feed(4, 1, 0);
    chk("t1_valid_lat6", 200'(bus.out_valid), 200'(1));
    chk("t1_low",        200'(bus.matrix_out[31:0]), 200'(32'h04030201));
    chk("t1_high",       200'(bus.matrix_out[199:32]), 200'(0));
    chk("t1_scalar",     200'(bus.scalar_out), 200'(8'hFD));
    chk("t1_size",       200'(bus.size_out), 200'(0));
    release_out(0, 1'b0, 2'b00);

    // 5x5 with every third cycle a bubble, then 10 cycles of backpressure
    for (int i = 0; i < 25; i++) stim[i] = 8'(i + 1);
    stim[25] = 8'h02;
    do_start(2'b11);
    feed(0, 26, 3);
    chk("t2_valid", 200'(bus.out_valid), 200'(1));
    chk("t2_count", 200'(elem_count), 200'(25));
    for (int i = 0; i < 25; i++) chk("t2_slot", 200'(bus.matrix_out[i*8 +: 8]), 200'(i + 1));
    release_out(10, 1'b0, 2'b00);
    chk("t3_valid_drop", 200'(bus.out_valid), 200'(0));
    chk("t3_busy_drop",  200'(busy), 200'(0));
    chk("t3_scalar_kept", 200'(bus.scalar_out), 200'(8'h02));
    chk("t3_slot0_kept",  200'(bus.matrix_out[7:0]), 200'(8'h01));

    // Asynchronous reset in the middle of a 3x3 load
    for (int i = 0; i < 10; i++) stim[i] = 8'($urandom_range(1, 255));
    do_start(2'b01);
    feed(0, 5, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_matrix", 200'(bus.matrix_out), 200'(0));
    chk("t4_scalar", 200'(bus.scalar_out), 200'(0));
    chk("t4_size",   200'(bus.size_out), 200'(0));
    chk("t4_valid",  200'(bus.out_valid), 200'(0));
    chk("t4_ready",  200'(bus.in_ready), 200'(0));
    chk("t4_busy",   200'(busy), 200'(0));
    chk("t4_count",  200'(elem_count), 200'(0));
    tick();
    rst_n = 1'b1;
    tick();
    do_start(2'b01);
    feed(0, 10, 0);
    chk("t4_valid_again", 200'(bus.out_valid), 200'(1));
    chk("t4_upper_zero",  200'(bus.matrix_out[199:72]), 200'(0));
    chk("t4_scalar_again", 200'(bus.scalar_out), 200'(stim[9]));
    release_out(2, 1'b0, 2'b00);

    // 4x4, start during the out_ready handshake is ignored; next 2x2 has no residue
    for (int i = 0; i < 17; i++) stim[i] = 8'($urandom_range(1, 255));
    do_start(2'b10);
    feed(0, 17, 0);
    release_out(1, 1'b1, 2'b11);
    chk("t5_start_ignored", 200'(busy), 200'(0));
    tick();
    for (int i = 0; i < 5; i++) stim[i] = 8'($urandom_range(1, 255));
    do_start(2'b00);
    feed(0, 5, 0);
    chk("t5_no_residue", 200'(bus.matrix_out[199:32]), 200'(0));
    chk("t5_size",       200'(bus.size_out), 200'(0));

    // Back-to-back 2x2 loads; second start in the first IDLE cycle
    release_out(0, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) stim[i] = 8'(8'h10 + i);
    do_start(2'b00);
    chk("t6_accept", 200'(busy), 200'(1));
    feed(0, 5, 0);
    chk("t6_scalar", 200'(bus.scalar_out), 200'(8'h14));
    chk("t6_low",    200'(bus.matrix_out[31:0]), 200'(32'h13121110));

    // Randomised loads
    for (int t = 0; t < 40; t++) begin
      logic [1:0] sz;
      int         n;
      release_out($urandom_range(0, 4), 1'($urandom_range(0, 1)), 2'($urandom));
      repeat ($urandom_range(0, 2)) tick();
      sz = 2'($urandom);
      n  = elems_for(sz);
      for (int i = 0; i < 26; i++) stim[i] = 8'($urandom);
      do_start(sz);
      feed(0, n + 1, -1);
    end
    release_out(1, 1'b0, 2'b00);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
